// File: rtl/SH7604_PKG.sv
// Shared types and constants for the on-chip interrupt arbiter: register layouts,
// bus addresses, reset values, write masks and the byte-merge helper.
package SH7604_PKG;

    localparam int NUM_SRC = 12;

    typedef struct packed {
        logic [3:0] divu;
        logic [3:0] dma;
        logic [3:0] wdt;
        logic [3:0] rsvd;
    } IPRA_t;

    typedef struct packed {
        logic [3:0] sci;
        logic [3:0] frt;
        logic [7:0] rsvd;
    } IPRB_t;

    typedef struct packed {
        logic       rsvd_h;
        logic [6:0] vec_h;
        logic       rsvd_l;
        logic [6:0] vec_l;
    } VCR_t;

    typedef enum logic [1:0] {IDLE, PEND, ACK} arb_state_e;

    localparam logic [31:0] ADDR_IPRB    = 32'hFFFF_FE60;
    localparam logic [31:0] ADDR_VCRA    = 32'hFFFF_FE62;
    localparam logic [31:0] ADDR_VCRB    = 32'hFFFF_FE64;
    localparam logic [31:0] ADDR_VCRC    = 32'hFFFF_FE66;
    localparam logic [31:0] ADDR_VCRD    = 32'hFFFF_FE68;
    localparam logic [31:0] ADDR_IPRA    = 32'hFFFF_FEE2;
    localparam logic [31:0] ADDR_VCRWDT  = 32'hFFFF_FEE4;
    localparam logic [31:0] ADDR_VCRDIV  = 32'hFFFF_FF0C;
    localparam logic [31:0] ADDR_VCRDMA0 = 32'hFFFF_FFA0;
    localparam logic [31:0] ADDR_VCRDMA1 = 32'hFFFF_FFA8;

    localparam IPRA_t      IPRA_INIT = '0;
    localparam IPRB_t      IPRB_INIT = '0;
    localparam VCR_t       VCR_INIT  = '0;
    localparam logic [6:0] VEC_INIT  = '0;

    localparam logic [15:0] IPRA_WMASK = 16'hFFF0;
    localparam logic [15:0] IPRB_WMASK = 16'hFF00;
    localparam logic [15:0] VCR2_WMASK = 16'h7F7F;
    localparam logic [15:0] VCR1_WMASK = 16'h7F00;

    localparam logic [7:0] SPURIOUS_VEC = 8'h18;

    // be[1] covers the upper byte of the halfword; unwritable bits always read back 0
    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] wdata,
                                            input logic [1:0] be, input logic [15:0] wmask);
        logic [15:0] bm;
        bm = {{8{be[1]}}, {8{be[0]}}};
        return ((old & ~bm) | (wdata & bm)) & wmask;
    endfunction

endpackage

// File: rtl/onchip_int_arb_if.sv
// Internal peripheral bus seen by the interrupt arbiter's register file.
interface onchip_int_arb_if;
    logic [31:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE;
    logic        IBUS_REQ;
    logic        IBUS_BUSY;
    logic        IBUS_ACT;

    modport master (output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
                    input  IBUS_DO, IBUS_BUSY, IBUS_ACT);
    modport slave  (input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
                    output IBUS_DO, IBUS_BUSY, IBUS_ACT);
endinterface

// File: rtl/int_prio_enc.sv
// Combinational winner select: highest level wins, lower index breaks ties.
module int_prio_enc
    import SH7604_PKG::*;
(
    input  logic [NUM_SRC-1:0]      req,
    input  logic [NUM_SRC-1:0][3:0] lvl,
    output logic [3:0]              level,
    output logic [3:0]              index
);

    // Strict greater-than keeps the first (lowest index) source on equal levels
    always_comb begin
        level = '0;
        index = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i] && (lvl[i] > level)) begin
                level = lvl[i];
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/onchip_int_arb.sv
// On-chip interrupt controller: IPR/VCR register file, priority arbitration
// and the vector acknowledge handshake towards the CPU.
module onchip_int_arb
    import SH7604_PKG::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CE_R,
    input  logic                   CE_F,
    onchip_int_arb_if.slave        ibus,
    input  logic [3:0]             FRT_IRQ,
    input  logic [3:0]             SCI_IRQ,
    input  logic                   WDT_IRQ,
    input  logic                   DIVU_IRQ,
    input  logic [1:0]             DMA_IRQ,
    output logic [3:0]             INT_LVL,
    input  logic                   INT_ACK,
    output logic [7:0]             INT_VEC,
    output logic                   VEC_VALID
);

    IPRA_t      ipra;
    IPRB_t      iprb;
    VCR_t       vcra, vcrb, vcrc, vcrd, vcrwdt;
    logic [6:0] vcrdiv, vcrdma0, vcrdma1;

    logic sel_fe60, sel_fe64, sel_fe68, sel_fee0, sel_fee4, sel_ff0c, sel_ffa0, sel_ffa8;
    logic wr_en;
    logic unused_addr_lsb;
    logic [31:0] rd_word, do_q;

    // Decode is per 32-bit word; byte enables pick the halfword/bytes inside it
    assign sel_fe60 = ibus.IBUS_A[31:2] == ADDR_IPRB[31:2];
    assign sel_fe64 = ibus.IBUS_A[31:2] == ADDR_VCRB[31:2];
    assign sel_fe68 = ibus.IBUS_A[31:2] == ADDR_VCRD[31:2];
    assign sel_fee0 = ibus.IBUS_A[31:2] == ADDR_IPRA[31:2];
    assign sel_fee4 = ibus.IBUS_A[31:2] == ADDR_VCRWDT[31:2];
    assign sel_ff0c = ibus.IBUS_A[31:2] == ADDR_VCRDIV[31:2];
    assign sel_ffa0 = ibus.IBUS_A[31:2] == ADDR_VCRDMA0[31:2];
    assign sel_ffa8 = ibus.IBUS_A[31:2] == ADDR_VCRDMA1[31:2];
    assign unused_addr_lsb = ^ibus.IBUS_A[1:0];

    assign ibus.IBUS_ACT  = ibus.IBUS_REQ & (sel_fe60 | sel_fe64 | sel_fe68 | sel_fee0 |
                                             sel_fee4 | sel_ff0c | sel_ffa0 | sel_ffa8);
    assign ibus.IBUS_BUSY = 1'b0;
    assign ibus.IBUS_DO   = ibus.IBUS_ACT ? do_q : '0;
    assign wr_en          = CE_R & ibus.IBUS_ACT & ibus.IBUS_WE;

    always_comb begin
        rd_word = '0;
        if (sel_fe60) rd_word = {iprb, vcra};
        if (sel_fe64) rd_word = {vcrb, vcrc};
        if (sel_fe68) rd_word = {vcrd, 16'h0000};
        if (sel_fee0) rd_word = {16'h0000, ipra};
        if (sel_fee4) rd_word = {vcrwdt, 16'h0000};
        if (sel_ff0c) rd_word = {25'h0, vcrdiv};
        if (sel_ffa0) rd_word = {25'h0, vcrdma0};
        if (sel_ffa8) rd_word = {25'h0, vcrdma1};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ipra    <= IPRA_INIT;
            iprb    <= IPRB_INIT;
            vcra    <= VCR_INIT;
            vcrb    <= VCR_INIT;
            vcrc    <= VCR_INIT;
            vcrd    <= VCR_INIT;
            vcrwdt  <= VCR_INIT;
            vcrdiv  <= VEC_INIT;
            vcrdma0 <= VEC_INIT;
            vcrdma1 <= VEC_INIT;
        end else if (wr_en) begin
            if (sel_fe60) begin
                iprb <= IPRB_t'(merge16(iprb, ibus.IBUS_DI[31:16], ibus.IBUS_BA[3:2], IPRB_WMASK));
                vcra <= VCR_t'(merge16(vcra, ibus.IBUS_DI[15:0], ibus.IBUS_BA[1:0], VCR2_WMASK));
            end
            if (sel_fe64) begin
                vcrb <= VCR_t'(merge16(vcrb, ibus.IBUS_DI[31:16], ibus.IBUS_BA[3:2], VCR2_WMASK));
                vcrc <= VCR_t'(merge16(vcrc, ibus.IBUS_DI[15:0], ibus.IBUS_BA[1:0], VCR2_WMASK));
            end
            if (sel_fe68)
                vcrd <= VCR_t'(merge16(vcrd, ibus.IBUS_DI[31:16], ibus.IBUS_BA[3:2], VCR1_WMASK));
            if (sel_fee0)
                ipra <= IPRA_t'(merge16(ipra, ibus.IBUS_DI[15:0], ibus.IBUS_BA[1:0], IPRA_WMASK));
            if (sel_fee4)
                vcrwdt <= VCR_t'(merge16(vcrwdt, ibus.IBUS_DI[31:16], ibus.IBUS_BA[3:2], VCR1_WMASK));
            if (sel_ff0c && ibus.IBUS_BA[0]) vcrdiv  <= ibus.IBUS_DI[6:0];
            if (sel_ffa0 && ibus.IBUS_BA[0]) vcrdma0 <= ibus.IBUS_DI[6:0];
            if (sel_ffa8 && ibus.IBUS_BA[0]) vcrdma1 <= ibus.IBUS_DI[6:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)       do_q <= '0;
        else if (CE_F) do_q <= ibus.IBUS_ACT ? rd_word : '0;
    end

    // Source index 0 (DIVU) is highest in the tie-break order, 11 (OVI) lowest
    logic [NUM_SRC-1:0]      src_req;
    logic [NUM_SRC-1:0][3:0] src_lvl;
    logic [NUM_SRC-1:0][6:0] src_vec;
    logic [3:0]              win_lvl, win_idx;

    assign src_req = {FRT_IRQ[0], FRT_IRQ[1], FRT_IRQ[2], FRT_IRQ[3],
                      SCI_IRQ[0], SCI_IRQ[1], SCI_IRQ[2], SCI_IRQ[3],
                      WDT_IRQ, DMA_IRQ[0], DMA_IRQ[1], DIVU_IRQ};
    assign src_lvl = {{4{iprb.frt}}, {4{iprb.sci}}, ipra.wdt, ipra.dma, ipra.dma, ipra.divu};
    assign src_vec = {vcrd.vec_h, vcrc.vec_l, vcrc.vec_l, vcrc.vec_h,
                      vcrb.vec_l, vcrb.vec_h, vcra.vec_l, vcra.vec_h,
                      vcrwdt.vec_h, vcrdma1, vcrdma0, vcrdiv};

    int_prio_enc u_prio_enc (
        .req   (src_req),
        .lvl   (src_lvl),
        .level (win_lvl),
        .index (win_idx)
    );

    arb_state_e state;
    logic       ack_q, ack_rise, any_pend;

    assign any_pend = win_lvl != 4'd0;
    assign ack_rise = INT_ACK & ~ack_q;

    // ack_q resets high so an acknowledge still held across reset is not taken as a new one
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            ack_q     <= 1'b1;
            INT_LVL   <= '0;
            INT_VEC   <= '0;
            VEC_VALID <= 1'b0;
        end else if (CE_R) begin
            ack_q   <= INT_ACK;
            INT_LVL <= win_lvl;
            case (state)
                IDLE, PEND: begin
                    if (ack_rise) begin
                        state     <= ACK;
                        INT_VEC   <= any_pend ? {1'b0, src_vec[win_idx]} : SPURIOUS_VEC;
                        VEC_VALID <= 1'b1;
                    end else begin
                        state <= any_pend ? PEND : IDLE;
                    end
                end
                ACK: begin
                    if (!INT_ACK) begin
                        state     <= IDLE;
                        VEC_VALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_int_arb.sv
// Directed self-checking bench for onchip_int_arb: register access, arbitration,
// acknowledge handshake, spurious vector and reset behaviour.
module tb_onchip_int_arb;

    logic       CLK = 1'b0;
    logic       RST, CE_R, CE_F;
    logic [3:0] FRT_IRQ, SCI_IRQ;
    logic       WDT_IRQ, DIVU_IRQ;
    logic [1:0] DMA_IRQ;
    logic [3:0] INT_LVL;
    logic       INT_ACK;
    logic [7:0] INT_VEC;
    logic       VEC_VALID;

    int n_checks = 0;
    int n_fail   = 0;

    onchip_int_arb_if ibus ();

    onchip_int_arb dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE_R      (CE_R),
        .CE_F      (CE_F),
        .ibus      (ibus),
        .FRT_IRQ   (FRT_IRQ),
        .SCI_IRQ   (SCI_IRQ),
        .WDT_IRQ   (WDT_IRQ),
        .DIVU_IRQ  (DIVU_IRQ),
        .DMA_IRQ   (DMA_IRQ),
        .INT_LVL   (INT_LVL),
        .INT_ACK   (INT_ACK),
        .INT_VEC   (INT_VEC),
        .VEC_VALID (VEC_VALID)
    );

    always #5 CLK = ~CLK;

    // Hard stop in case the sequence below ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] frt, input logic [3:0] sci, input logic wdt,
                                  input logic divu, input logic [1:0] dma, input logic ack);
        FRT_IRQ  = frt;
        SCI_IRQ  = sci;
        WDT_IRQ  = wdt;
        DIVU_IRQ = divu;
        DMA_IRQ  = dma;
        INT_ACK  = ack;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        ibus.IBUS_A   = addr;
        ibus.IBUS_DI  = data;
        ibus.IBUS_BA  = be;
        ibus.IBUS_WE  = 1'b1;
        ibus.IBUS_REQ = 1'b1;
        cycles(1);
        ibus.IBUS_WE  = 1'b0;
        ibus.IBUS_REQ = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        ibus.IBUS_A   = addr;
        ibus.IBUS_BA  = 4'hF;
        ibus.IBUS_WE  = 1'b0;
        ibus.IBUS_REQ = 1'b1;
        CE_F          = 1'b1;
        cycles(1);
        CE_F          = 1'b0;
        check_output(tag, ibus.IBUS_DO, expected);
        ibus.IBUS_REQ = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        CE_R = 1'b0;
        CE_F = 1'b0;
        ibus.IBUS_A   = '0;
        ibus.IBUS_DI  = '0;
        ibus.IBUS_BA  = '0;
        ibus.IBUS_WE  = 1'b0;
        ibus.IBUS_REQ = 1'b0;
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Reset with CE_R low must still clear everything
        cycles(2);
        check_output("rst_lvl", 32'(INT_LVL), 32'h0);
        check_output("rst_valid", 32'(VEC_VALID), 32'h0);
        check_output("rst_vec", 32'(INT_VEC), 32'h0);
        check_output("rst_busy", 32'(ibus.IBUS_BUSY), 32'h0);
        RST  = 1'b0;
        CE_R = 1'b1;
        check_reg("rst_ipra", 32'hFFFF_FEE2, 32'h0);

        // Write masks and big-endian byte lanes
        bus_write(32'hFFFF_FE60, 32'hFFFF_0000, 4'b1100);
        check_reg("iprb_mask", 32'hFFFF_FE60, 32'hFF00_0000);
        bus_write(32'hFFFF_FE63, 32'h0000_00FF, 4'b0001);
        check_reg("vcra_byte1", 32'hFFFF_FE62, 32'hFF00_007F);
        bus_write(32'hFFFF_FEE2, 32'h0000_FFFF, 4'b0011);
        check_reg("ipra_mask", 32'hFFFF_FEE2, 32'h0000_FFF0);
        bus_write(32'hFFFF_FF0C, 32'hFFFF_FFFF, 4'hF);
        check_reg("vcrdiv_mask", 32'hFFFF_FF0C, 32'h0000_007F);
        bus_write(32'hFFFF_FE64, 32'h9122_B344, 4'hF);
        check_reg("vcrbc_word", 32'hFFFF_FE64, 32'h1122_3344);

        CE_R = 1'b0;
        bus_write(32'hFFFF_FEE2, 32'h0000_1230, 4'b0011);
        CE_R = 1'b1;
        check_reg("ce_r_gate", 32'hFFFF_FEE2, 32'h0000_FFF0);

        ibus.IBUS_A   = 32'hFFFF_FE6C;
        ibus.IBUS_REQ = 1'b1;
        CE_F          = 1'b1;
        cycles(1);
        CE_F          = 1'b0;
        check_output("unmapped_act", 32'(ibus.IBUS_ACT), 32'h0);
        check_output("unmapped_do", ibus.IBUS_DO, 32'h0);
        ibus.IBUS_A = 32'hFFFF_FE66;
        #1;
        check_output("mapped_act", 32'(ibus.IBUS_ACT), 32'h1);
        ibus.IBUS_REQ = 1'b0;

        // FRT OCIA at level 5 with OCI vector 0x42
        bus_write(32'hFFFF_FEE2, 32'h0000_0000, 4'b0011);
        bus_write(32'hFFFF_FE60, 32'h0500_0000, 4'b1100);
        bus_write(32'hFFFF_FE66, 32'h0000_0042, 4'b0011);
        apply_stimulus(4'b0100, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(1);
        check_output("oci_lvl", 32'(INT_LVL), 32'h5);
        check_output("oci_pend_valid", 32'(VEC_VALID), 32'h0);
        apply_stimulus(4'b0100, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
        cycles(1);
        check_output("oci_vec", 32'(INT_VEC), 32'h42);
        check_output("oci_valid", 32'(VEC_VALID), 32'h1);
        check_output("oci_ack_lvl", 32'(INT_LVL), 32'h5);

        // Source left pending re-raises after the handshake; OCIB shares the OCI vector
        apply_stimulus(4'b0100, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(1);
        check_output("rel_valid", 32'(VEC_VALID), 32'h0);
        check_output("rel_lvl", 32'(INT_LVL), 32'h5);
        cycles(1);
        apply_stimulus(4'b0010, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
        cycles(1);
        check_output("ocib_vec", 32'(INT_VEC), 32'h42);
        check_output("ocib_valid", 32'(VEC_VALID), 32'h1);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(2);
        check_output("idle_lvl", 32'(INT_LVL), 32'h0);
        check_output("idle_valid", 32'(VEC_VALID), 32'h0);

        // WDT and RXI tie at level 7: WDT wins, then RXI
        bus_write(32'hFFFF_FEE2, 32'h0000_0070, 4'b0011);
        bus_write(32'hFFFF_FE60, 32'h7500_0000, 4'b1100);
        bus_write(32'hFFFF_FEE4, 32'h2A00_0000, 4'b1100);
        bus_write(32'hFFFF_FE62, 32'h0000_0033, 4'b0011);
        apply_stimulus(4'h0, 4'b0100, 1'b1, 1'b0, 2'b00, 1'b0);
        cycles(1);
        check_output("tie_lvl", 32'(INT_LVL), 32'h7);
        apply_stimulus(4'h0, 4'b0100, 1'b1, 1'b0, 2'b00, 1'b1);
        cycles(1);
        check_output("tie_wdt_vec", 32'(INT_VEC), 32'h2A);
        apply_stimulus(4'h0, 4'b0100, 1'b0, 1'b0, 2'b00, 0);
        cycles(2);
        check_output("rxi_pend_lvl", 32'(INT_LVL), 32'h7);
        check_output("rxi_pend_valid", 32'(VEC_VALID), 32'h0);
        apply_stimulus(4'h0, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b1);
        cycles(1);
        check_output("rxi_vec", 32'(INT_VEC), 32'h33);

        // Level forced to 0 while RXI still pending
        apply_stimulus(4'h0, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(2);
        bus_write(32'hFFFF_FE60, 32'h0500_0000, 4'b1100);
        cycles(1);
        check_output("lvl_zero_drop", 32'(INT_LVL), 32'h0);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);

        // DIVU withdrawn before acknowledge gives the spurious vector
        bus_write(32'hFFFF_FEE2, 32'h0000_3070, 4'b0011);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0);
        cycles(1);
        check_output("divu_lvl", 32'(INT_LVL), 32'h3);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(1);
        check_output("divu_drop_lvl", 32'(INT_LVL), 32'h0);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b1);
        cycles(1);
        check_output("spurious_vec", 32'(INT_VEC), 32'h18);
        check_output("spurious_valid", 32'(VEC_VALID), 32'h1);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(1);
        check_output("spurious_rel", 32'(VEC_VALID), 32'h0);

        // Register writes during ACK move INT_LVL but not the frozen vector
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0);
        cycles(1);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1);
        cycles(1);
        check_output("divu_vec", 32'(INT_VEC), 32'h7F);
        bus_write(32'hFFFF_FEE2, 32'h0000_F070, 4'b0011);
        cycles(1);
        check_output("ack_lvl_15", 32'(INT_LVL), 32'hF);
        bus_write(32'hFFFF_FF0C, 32'h0000_0011, 4'b0001);
        cycles(1);
        check_output("ack_vec_frozen", 32'(INT_VEC), 32'h7F);
        check_output("ack_valid_held", 32'(VEC_VALID), 32'h1);

        // Reset while in ACK with INT_ACK still high
        RST = 1'b1;
        cycles(1);
        check_output("rst_ack_lvl", 32'(INT_LVL), 32'h0);
        check_output("rst_ack_valid", 32'(VEC_VALID), 32'h0);
        check_output("rst_ack_vec", 32'(INT_VEC), 32'h0);
        RST = 1'b0;
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b00, 1'b0);
        check_reg("rst_ack_ipra", 32'hFFFF_FEE2, 32'h0);
        check_reg("rst_ack_vcrdiv", 32'hFFFF_FF0C, 32'h0);
        check_reg("rst_ack_fe60", 32'hFFFF_FE60, 32'h0);
        check_output("rst_ack_lvl_after", 32'(INT_LVL), 32'h0);

        // DMA channels share a level; ch0 beats ch1 on the tie
        bus_write(32'hFFFF_FEE2, 32'h0000_0200, 4'b0011);
        bus_write(32'hFFFF_FFA8, 32'h0000_0055, 4'hF);
        bus_write(32'hFFFF_FFA0, 32'h0000_0066, 4'hF);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b01, 1'b0);
        cycles(1);
        check_output("dma1_lvl", 32'(INT_LVL), 32'h2);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b01, 1'b1);
        cycles(1);
        check_output("dma1_vec", 32'(INT_VEC), 32'h55);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b11, 1'b0);
        cycles(2);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 2'b11, 1'b1);
        cycles(1);
        check_output("dma0_vec", 32'(INT_VEC), 32'h66);
        apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
